sc_fifo_thr: RTL and testbench

Parametrised single-clock FIFO with configurable width and depth, a registered fill level, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags and a synchronous flush. It is the single-clock-domain successor to the team's symmetric dual-clock FIFO. It sits inside the DMA interface datapath wherever producer and consumer share one clock.

---
 rtl/sc_fifo_thr.sv | 121 ++++++++++++
 tb/tb_sc_fifo_thr.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sc_fifo_thr.sv
// sc_fifo_thr: single-clock FIFO, registered level/flags, almost thresholds, sticky errors, flush.
// Latency: standard mode 1 cycle rd_en->dout; define SC_FIFO_FWFT_EN for first-word-fall-through.
// Backpressure: writes dropped while full, reads dropped while empty; both raise sticky flags.
module sc_fifo_thr #(
  parameter int DATA_WIDTH    = 64,
  parameter int MEM_SIZE      = 1024,
  parameter int AFULL_THRESH  = MEM_SIZE - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       din,
  input  logic                        rd_en,
  output logic [DATA_WIDTH-1:0]       dout,
  output logic                        valid_out,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [$clog2(MEM_SIZE):0]   level,
  output logic                        overflow,
  output logic                        underflow,
  input  logic                        clr_err
);

  localparam int ADDR_WIDTH = $clog2(MEM_SIZE);
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL  = MEM_SIZE[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_LVL     = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_LVL     = AEMPTY_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LVL_ONE    = 1;
  localparam logic [ADDR_WIDTH:0] LVL_ZERO   = '0;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   level_nxt;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_rd;
  logic                  valid_nxt;

  always_comb begin
    wr_acc = wr_en & ~full;
    rd_acc = rd_en & ~empty;
`ifdef SC_FIFO_FWFT_EN
    // Refill the output register whenever it is free or being consumed this cycle.
    mem_rd    = (wr_ptr != rd_ptr) & (~valid_out | rd_en);
    valid_nxt = mem_rd | (valid_out & ~rd_en);
`else
    mem_rd    = rd_acc;
    valid_nxt = rd_acc;
`endif
    level_nxt = level;
    if (wr_acc && !rd_acc)
      level_nxt = level + LVL_ONE;
    else if (rd_acc && !wr_acc)
      level_nxt = level - LVL_ONE;
  end

  // Unreset storage so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && wr_acc)
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      dout         <= '0;
      valid_out    <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        level        <= '0;
        valid_out    <= 1'b0;
        full         <= 1'b0;
        empty        <= 1'b1;
        almost_full  <= 1'b0;
        almost_empty <= 1'b1;
      end else begin
        if (wr_acc)
          wr_ptr <= wr_ptr + LVL_ONE;
        if (mem_rd) begin
          rd_ptr <= rd_ptr + LVL_ONE;
          dout   <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
        valid_out    <= valid_nxt;
        level        <= level_nxt;
        full         <= (level_nxt == DEPTH_LVL);
`ifdef SC_FIFO_FWFT_EN
        empty        <= ~valid_nxt;
`else
        empty        <= (level_nxt == LVL_ZERO);
`endif
        almost_full  <= (level_nxt >= AF_LVL);
        almost_empty <= (level_nxt <= AE_LVL);
      end
      // Set wins over clear; requests in a flush cycle are ignored.
      if (!flush && wr_en && full)
        overflow <= 1'b1;
      else if (clr_err)
        overflow <= 1'b0;
      if (!flush && rd_en && empty)
        underflow <= 1'b1;
      else if (clr_err)
        underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sc_fifo_thr.sv
// Directed bench for sc_fifo_thr in standard (non-FWFT) mode with default parameters.
module tb_sc_fifo_thr;

  logic        clk = 1'b0;
  logic        rst_n, flush, wr_en, rd_en, clr_err;
  logic [63:0] din;
  logic [63:0] dout;
  logic        valid_out, full, empty, almost_full, almost_empty;
  logic [10:0] level;
  logic        overflow, underflow;

  int total = 0;
  int bad   = 0;
  longint wv, rv;

  always #5 clk = ~clk;

  sc_fifo_thr dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_dout"}, dout, 0);
    chk({pfx, "_valid"}, valid_out, 0);
    chk({pfx, "_full"}, full, 0);
    chk({pfx, "_empty"}, empty, 1);
    chk({pfx, "_afull"}, almost_full, 0);
    chk({pfx, "_aempty"}, almost_empty, 1);
    chk({pfx, "_level"}, level, 0);
    chk({pfx, "_ovf"}, overflow, 0);
    chk({pfx, "_udf"}, underflow, 0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
    tick(); tick();
    chk_reset_state("rst");
    rst_n = 1'b1;

    // Fill 0..1023
    wr_en = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      din = 64'(i);
      tick();
      chk("fill_level", level, 64'(i + 1));
      if (i + 1 == 4)    chk("fill_ae4", almost_empty, 1);
      if (i + 1 == 5)    chk("fill_ae5", almost_empty, 0);
      if (i + 1 == 1019) chk("fill_af1019", almost_full, 0);
      if (i + 1 == 1020) chk("fill_af1020", almost_full, 1);
      if (i + 1 == 1023) chk("fill_full1023", full, 0);
    end
    chk("fill_full", full, 1);
    chk("fill_empty", empty, 0);

    din = 64'hDEAD;
    tick();
    chk("ovf_set", overflow, 1);
    chk("ovf_level", level, 1024);
    wr_en = 1'b0;
    clr_err = 1'b1;
    tick();
    chk("ovf_clr", overflow, 0);
    clr_err = 1'b0;

    // Drain, expecting 0..1023 with no trace of the rejected write
    rd_en = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      tick();
      chk("drain_dout", dout, 64'(i));
      chk("drain_valid", valid_out, 1);
      chk("drain_level", level, 64'(1023 - i));
      if (1023 - i == 1020) chk("drain_af1020", almost_full, 1);
      if (1023 - i == 1019) chk("drain_af1019", almost_full, 0);
      if (1023 - i == 5)    chk("drain_ae5", almost_empty, 0);
      if (1023 - i == 4)    chk("drain_ae4", almost_empty, 1);
    end
    chk("drain_empty", empty, 1);
    rd_en = 1'b0;
    tick();
    chk("hold_valid", valid_out, 0);
    chk("hold_dout", dout, 1023);
    rd_en = 1'b1;
    tick();
    chk("udf_set", underflow, 1);
    chk("udf_valid", valid_out, 0);
    chk("udf_level", level, 0);
    rd_en = 1'b0;
    clr_err = 1'b1;
    tick();
    chk("udf_clr", underflow, 0);
    clr_err = 1'b0;

    // Concurrent traffic at level 512 across the pointer wrap
    wv = 5000; rv = 5000;
    wr_en = 1'b1;
    for (int i = 0; i < 512; i++) begin
      din = 64'(wv); wv++;
      tick();
    end
    chk("conc_start_level", level, 512);
    rd_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      din = 64'(wv); wv++;
      tick();
      chk("conc_dout", dout, 64'(rv)); rv++;
      chk("conc_level", level, 512);
    end
    rd_en = 1'b0;
    for (int i = 0; i < 512; i++) begin
      din = 64'(wv); wv++;
      tick();
    end
    chk("refill_full", full, 1);
    chk("refill_level", level, 1024);

    // Full with simultaneous read and write: read wins, write rejected
    rd_en = 1'b1; din = 64'hBAD;
    tick();
    chk("fullrw_level", level, 1023);
    chk("fullrw_dout", dout, 64'(rv)); rv++;
    chk("fullrw_ovf", overflow, 1);
    chk("fullrw_full", full, 0);
    wr_en = 1'b0;
    for (int i = 0; i < 1023; i++) begin
      tick();
      chk("fullrw_drain", dout, 64'(rv)); rv++;
    end
    chk("fullrw_drained", empty, 1);
    chk("fullrw_wv_rv", 64'(rv), 64'(wv));

    // Empty with simultaneous read and write: write wins, read rejected
    wr_en = 1'b1; din = 64'h77;
    tick();
    chk("emptyrw_level", level, 1);
    chk("emptyrw_udf", underflow, 1);
    chk("emptyrw_valid", valid_out, 0);
    chk("emptyrw_empty", empty, 0);
    wr_en = 1'b0;
    tick();
    chk("emptyrw_dout", dout, 64'h77);
    chk("emptyrw_valid2", valid_out, 1);
    chk("emptyrw_empty2", empty, 1);
    rd_en = 1'b0;

    // Flush at level 300 with a write pending
    wr_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      din = 64'(i + 200);
      tick();
    end
    chk("preflush_level", level, 300);
    flush = 1'b1; din = 64'h1234;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_empty", empty, 1);
    chk("flush_full", full, 0);
    chk("flush_valid", valid_out, 0);
    chk("flush_ae", almost_empty, 1);
    chk("flush_ovf", overflow, 1);
    chk("flush_udf", underflow, 1);
    wr_en = 1'b1; din = 64'hA5;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("flush_rd_dout", dout, 64'hA5);
    chk("flush_rd_valid", valid_out, 1);
    chk("flush_rd_level", level, 0);

    // Reset mid-stream, with flush and write also asserted
    wr_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      din = 64'(i + 9000);
      tick();
    end
    chk("prerst_level", level, 100);
    chk("prerst_ovf", overflow, 1);
    rst_n = 1'b0; flush = 1'b1;
    tick();
    chk_reset_state("midrst");
    rst_n = 1'b1; flush = 1'b0; wr_en = 1'b0; clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_noop_ovf", overflow, 0);
    chk("clr_noop_udf", underflow, 0);
    chk("clr_noop_level", level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
